req_arbiter8: RTL and testbench

Eight-requester arbiter that shares one downstream resource among up to eight masters, using the same priority ordering as the 8-to-3 priority encoder: index 7 is highest. It takes a one-hot-or-multi-hot request vector and issues a registered one-hot grant plus its 3-bit encoded index. A grant is held until the owner releases it or a hold timeout expires. Fixed-priority or round-robin selection is chosen by parameter. It sits between the requesting blocks and the shared datapath select.

---
 rtl/req_arbiter8.sv | 120 ++++++++++++
 tb/tb_req_arbiter8.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/req_arbiter8.sv
// rtl/req_arbiter8.sv - eight-requester arbiter, fixed-priority or round-robin, with hold timeout
module req_arbiter8 #(
    parameter int RR_EN    = 1,
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_vld,
    output logic       timeout
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    localparam logic [7:0] HOLD_LAST = 8'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    logic [1:0] r_state;
    logic [7:0] r_gnt;
    logic [2:0] r_gnt_id;
    logic       r_gnt_vld;
    logic       r_timeout;
    logic [7:0] r_hold_cnt;
    logic [2:0] r_last_id;

    logic [2:0] w_win;
    logic       w_found;
    logic       w_any;
    logic       w_owner_req;
    logic       w_hold_hit;
    logic       w_release;

    // Round-robin walks downward from last_id-1 and reaches last_id itself on the eighth step.
    always_comb begin
        w_win   = 3'd0;
        w_found = 1'b0;
        if (RR_EN != 0) begin
            for (int k = 1; k <= 8; k++) begin
                logic [2:0] w_idx;
                w_idx = r_last_id - 3'(k);
                if (!w_found && req[w_idx]) begin
                    w_win   = w_idx;
                    w_found = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (req[i]) begin
                    w_win   = 3'(i);
                    w_found = 1'b1;
                end
            end
        end
    end

    assign w_any       = |req;
    assign w_owner_req = req[r_gnt_id];
    assign w_hold_hit  = (MAX_HOLD != 0) && (r_hold_cnt == HOLD_LAST);
    assign w_release   = done || !w_owner_req || w_hold_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_gnt      <= 8'd0;
            r_gnt_id   <= 3'd0;
            r_gnt_vld  <= 1'b0;
            r_timeout  <= 1'b0;
            r_hold_cnt <= 8'd0;
            r_last_id  <= 3'd0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE, ST_GAP: begin
                    if (w_any) begin
                        r_state    <= ST_GRANT;
                        r_gnt      <= 8'd1 << w_win;
                        r_gnt_id   <= w_win;
                        r_gnt_vld  <= 1'b1;
                        r_hold_cnt <= 8'd0;
                        r_last_id  <= w_win;
                    end else begin
                        r_state   <= ST_IDLE;
                        r_gnt     <= 8'd0;
                        r_gnt_id  <= 3'd0;
                        r_gnt_vld <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    if (r_hold_cnt != 8'hFF) begin
                        r_hold_cnt <= r_hold_cnt + 8'd1;
                    end
                    if (w_release) begin
                        r_state   <= ST_GAP;
                        r_gnt     <= 8'd0;
                        r_gnt_id  <= 3'd0;
                        r_gnt_vld <= 1'b0;
                        // Timeout is flagged only when the hold limit was the sole cause.
                        r_timeout <= w_hold_hit && !done && w_owner_req;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_gnt     <= 8'd0;
                    r_gnt_id  <= 3'd0;
                    r_gnt_vld <= 1'b0;
                end
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign gnt_id  = r_gnt_id;
    assign gnt_vld = r_gnt_vld;
    assign timeout = r_timeout;

endmodule

// File: tb/tb_req_arbiter8.sv
// tb/tb_req_arbiter8.sv - directed table-driven bench for req_arbiter8 (fixed-priority and round-robin)
module tb_req_arbiter8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] fp_req, rr_req;
    logic       fp_done, rr_done;
    logic [7:0] fp_gnt, rr_gnt;
    logic [2:0] fp_gnt_id, rr_gnt_id;
    logic       fp_gnt_vld, rr_gnt_vld;
    logic       fp_timeout, rr_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    req_arbiter8 #(.RR_EN(0), .MAX_HOLD(4)) u_fp (
        .clk(clk), .rst_n(rst_n), .req(fp_req), .done(fp_done),
        .gnt(fp_gnt), .gnt_id(fp_gnt_id), .gnt_vld(fp_gnt_vld), .timeout(fp_timeout)
    );

    req_arbiter8 #(.RR_EN(1), .MAX_HOLD(4)) u_rr (
        .clk(clk), .rst_n(rst_n), .req(rr_req), .done(rr_done),
        .gnt(rr_gnt), .gnt_id(rr_gnt_id), .gnt_vld(rr_gnt_vld), .timeout(rr_timeout)
    );

    typedef struct {
        logic [7:0] req;
        logic       done;
        logic [2:0] id;
        logic       vld;
        logic       to;
    } vec_t;

    vec_t tbl [32];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rr(input string name, input logic [2:0] id, input logic vld, input logic to);
        chk({name, " rr gnt_id"}, 8'(rr_gnt_id), 8'(id));
        chk({name, " rr gnt_vld"}, 8'(rr_gnt_vld), 8'(vld));
        chk({name, " rr gnt"}, rr_gnt, vld ? (8'd1 << id) : 8'd0);
        chk({name, " rr timeout"}, 8'(rr_timeout), 8'(to));
    endtask

    logic [2:0] rr_seq [9];

    initial begin
        // Fixed-priority, MAX_HOLD=4 stimulus/expectations: {req, done, gnt_id, gnt_vld, timeout}
        tbl[0]  = '{8'h2C, 1'b0, 3'd5, 1'b1, 1'b0};
        tbl[1]  = '{8'h2C, 1'b1, 3'd0, 1'b0, 1'b0};
        tbl[2]  = '{8'h2C, 1'b0, 3'd5, 1'b1, 1'b0};
        tbl[3]  = '{8'h2C, 1'b0, 3'd5, 1'b1, 1'b0};
        tbl[4]  = '{8'hAC, 1'b0, 3'd5, 1'b1, 1'b0};
        tbl[5]  = '{8'hAC, 1'b0, 3'd5, 1'b1, 1'b0};
        tbl[6]  = '{8'hAC, 1'b0, 3'd0, 1'b0, 1'b1};
        tbl[7]  = '{8'hAC, 1'b0, 3'd7, 1'b1, 1'b0};
        tbl[8]  = '{8'hA8, 1'b0, 3'd7, 1'b1, 1'b0};
        tbl[9]  = '{8'h28, 1'b0, 3'd0, 1'b0, 1'b0};
        tbl[10] = '{8'h28, 1'b0, 3'd5, 1'b1, 1'b0};
        tbl[11] = '{8'h00, 1'b0, 3'd0, 1'b0, 1'b0};
        tbl[12] = '{8'h00, 1'b0, 3'd0, 1'b0, 1'b0};
        tbl[13] = '{8'h00, 1'b1, 3'd0, 1'b0, 1'b0};
        tbl[14] = '{8'h01, 1'b0, 3'd0, 1'b1, 1'b0};
        tbl[15] = '{8'h01, 1'b0, 3'd0, 1'b1, 1'b0};
        tbl[16] = '{8'h01, 1'b0, 3'd0, 1'b1, 1'b0};
        tbl[17] = '{8'h01, 1'b0, 3'd0, 1'b1, 1'b0};
        tbl[18] = '{8'h01, 1'b0, 3'd0, 1'b0, 1'b1};
        tbl[19] = '{8'h01, 1'b0, 3'd0, 1'b1, 1'b0};
        tbl[20] = '{8'h01, 1'b0, 3'd0, 1'b1, 1'b0};
        tbl[21] = '{8'h01, 1'b0, 3'd0, 1'b1, 1'b0};
        tbl[22] = '{8'h01, 1'b0, 3'd0, 1'b1, 1'b0};
        tbl[23] = '{8'h01, 1'b1, 3'd0, 1'b0, 1'b0};
        tbl[24] = '{8'h01, 1'b0, 3'd0, 1'b1, 1'b0};
        tbl[25] = '{8'h08, 1'b0, 3'd0, 1'b0, 1'b0};
        tbl[26] = '{8'h0A, 1'b0, 3'd3, 1'b1, 1'b0};
        tbl[27] = '{8'h0A, 1'b0, 3'd3, 1'b1, 1'b0};
        tbl[28] = '{8'h02, 1'b0, 3'd0, 1'b0, 1'b0};
        tbl[29] = '{8'h02, 1'b0, 3'd1, 1'b1, 1'b0};
        tbl[30] = '{8'h00, 1'b0, 3'd0, 1'b0, 1'b0};
        tbl[31] = '{8'h00, 1'b0, 3'd0, 1'b0, 1'b0};

        rr_seq = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};

        rst_n = 1'b0; fp_req = 8'hFF; rr_req = 8'hFF; fp_done = 1'b0; rr_done = 1'b0;
        tick(); tick();
        chk("reset fp gnt", fp_gnt, 8'd0);
        chk("reset fp gnt_id", 8'(fp_gnt_id), 8'd0);
        chk("reset fp gnt_vld", 8'(fp_gnt_vld), 8'd0);
        chk("reset fp timeout", 8'(fp_timeout), 8'd0);
        chk_rr("reset", 3'd0, 1'b0, 1'b0);

        fp_req = 8'h00; rr_req = 8'h00;
        rst_n = 1'b1;
        #2;
        chk("post-release fp gnt_vld", 8'(fp_gnt_vld), 8'd0);
        tick();

        for (int i = 0; i < 32; i++) begin
            string nm;
            nm = $sformatf("fp row %0d", i);
            fp_req  = tbl[i].req;
            fp_done = tbl[i].done;
            tick();
            chk({nm, " gnt_id"}, 8'(fp_gnt_id), 8'(tbl[i].id));
            chk({nm, " gnt_vld"}, 8'(fp_gnt_vld), 8'(tbl[i].vld));
            chk({nm, " gnt"}, fp_gnt, tbl[i].vld ? (8'd1 << tbl[i].id) : 8'd0);
            chk({nm, " timeout"}, 8'(fp_timeout), 8'(tbl[i].to));
        end
        fp_done = 1'b0;

        // Round-robin rotation with all requesters active.
        rr_req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            rr_done = 1'b0;
            tick();
            chk_rr($sformatf("rot %0d grant", k), rr_seq[k], 1'b1, 1'b0);
            rr_done = 1'b1;
            tick();
            chk_rr($sformatf("rot %0d gap", k), 3'd0, 1'b0, 1'b0);
        end
        rr_done = 1'b0;

        // Sole requester wins again after its own release.
        rr_req = 8'h08;
        tick(); chk_rr("solo first", 3'd3, 1'b1, 1'b0);
        rr_done = 1'b1; tick(); chk_rr("solo gap", 3'd0, 1'b0, 1'b0);
        rr_done = 1'b0; tick(); chk_rr("solo again", 3'd3, 1'b1, 1'b0);
        rr_done = 1'b1; tick(); chk_rr("solo gap2", 3'd0, 1'b0, 1'b0);

        // last_id=3: search 2,1,0,7,... so 2 beats 3.
        rr_done = 1'b0; rr_req = 8'h0C;
        tick(); chk_rr("rr after 3", 3'd2, 1'b1, 1'b0);

        // Asynchronous reset mid-grant, then last_id must restart at 0.
        rst_n = 1'b0;
        #1;
        chk_rr("async reset", 3'd0, 1'b0, 1'b0);
        tick();
        chk_rr("reset held", 3'd0, 1'b0, 1'b0);
        rr_req = 8'h05;
        #2;
        rst_n = 1'b1;
        #1;
        chk_rr("reset released", 3'd0, 1'b0, 1'b0);
        tick();
        chk_rr("first after reset", 3'd2, 1'b1, 1'b0);

        rr_req = 8'h00;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
